// File: rtl/xb_mem8_arbiter.sv
// rtl/xb_mem8_arbiter.sv - mem_8 seekable stream backing bank shared with one local requester
//
// Purpose: backs the host mem_8 write/read stream pair with a DEPTH x 8
// register bank. The bank has a single access port per cycle, which is shared
// by the host sequencer and one local fabric requester.
//
// Optional feature macro: XB_MEM8_WRAP_EN
//   defined   - the host pointer wraps modulo DEPTH, eof is tied 0 and no host
//               write is discarded.
//   undefined - the pointer saturates at DEPTH, writes at ptr>=DEPTH are
//               dropped and eof is raised at DEPTH.
//
// Ports:
//   bus_clk_w                 clock
//   trn_reset_n_w             asynchronous active-low reset
//   user_mem_8_addr_w         host seek address
//   user_mem_8_addr_update_w  load the seek address
//   user_w_mem_8_*            host write stream: open, wren, data in; full out
//   user_r_mem_8_*            host read stream: open, rden in; data, empty, eof out
//   loc_req_w / loc_we_w      local request (held until grant) and direction
//   loc_addr_w / loc_wdata_w  local address and write byte
//   loc_gnt_w                 single-cycle grant; the access happens in that cycle
//   loc_rdata_w / loc_rvalid_w  local read data, valid one cycle after a read grant
module xb_mem8_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          bus_clk_w,
  input  logic          trn_reset_n_w,
  input  logic [AW-1:0] user_mem_8_addr_w,
  input  logic          user_mem_8_addr_update_w,
  input  logic          user_w_mem_8_open_w,
  input  logic          user_w_mem_8_wren_w,
  input  logic [7:0]    user_w_mem_8_data_w,
  output logic          user_w_mem_8_full_w,
  input  logic          user_r_mem_8_open_w,
  input  logic          user_r_mem_8_rden_w,
  output logic [7:0]    user_r_mem_8_data_w,
  output logic          user_r_mem_8_empty_w,
  output logic          user_r_mem_8_eof_w,
  input  logic          loc_req_w,
  input  logic          loc_we_w,
  input  logic [AW-1:0] loc_addr_w,
  input  logic [7:0]    loc_wdata_w,
  output logic          loc_gnt_w,
  output logic [7:0]    loc_rdata_w,
  output logic          loc_rvalid_w
);

  typedef enum logic [2:0] {S_IDLE, S_WCOMMIT, S_FETCH, S_VALID, S_EOF} state_t;

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Reset asserts asynchronously, releases on a clock edge.
  logic rst_meta_q, rst_n_sync;
  always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
    if (!trn_reset_n_w) begin
      rst_meta_q <= 1'b0;
      rst_n_sync <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_sync <= rst_meta_q;
    end
  end

  logic [7:0]    bank_q [DEPTH];
  logic [AW:0]   ptr_q, ptr_d;
  logic          wbuf_vld_q, wbuf_vld_d;
  logic [AW-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [7:0]    wbuf_data_q, wbuf_data_d;
  state_t        state_q, state_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          tok_q, tok_d;             // 0 = host owns the next contested grant
  logic [7:0]    loc_rdata_q, loc_rdata_d;
  logic          loc_rvalid_q, loc_rvalid_d;

  logic          r_open, pf_vld, w_acc, r_acc, in_range, eof_hit;
  logic [AW:0]   ptr_inc;
  logic          h_wreq, h_rreq, h_req, l_req, h_gnt, l_gnt, contested;
  logic          bw_en, inval;
  logic [AW-1:0] bw_addr;
  logic [7:0]    bw_data;

  assign r_open = user_r_mem_8_open_w;
  assign pf_vld = (state_q == S_FETCH) || (state_q == S_VALID);
  assign w_acc  = user_w_mem_8_wren_w & ~wbuf_vld_q & user_w_mem_8_open_w;
  assign r_acc  = user_r_mem_8_rden_w & pf_vld & r_open;

`ifdef XB_MEM8_WRAP_EN
  assign in_range = 1'b1;
  assign ptr_inc  = {1'b0, ptr_q[AW-1:0] + PTR_ONE[AW-1:0]};
  assign eof_hit  = 1'b0;
`else
  localparam logic [AW:0] PTR_END = (AW+1)'(DEPTH);
  assign in_range = (ptr_q < PTR_END);
  assign ptr_inc  = in_range ? ptr_q + PTR_ONE : ptr_q;
  assign eof_hit  = (ptr_q == PTR_END) & r_open;
`endif

  // A prefetch is not started while the pointer is being moved this cycle,
  // otherwise the fetched byte would belong to the old pointer.
  assign h_wreq    = wbuf_vld_q;
  assign h_rreq    = (state_q == S_IDLE) & ~wbuf_vld_q & r_open & in_range &
                     ~user_mem_8_addr_update_w & ~w_acc;
  assign h_req     = h_wreq | h_rreq;
  assign l_req     = loc_req_w;
  assign contested = h_req & l_req;
  assign l_gnt     = rst_n_sync & l_req & (~h_req | tok_q);
  assign h_gnt     = rst_n_sync & h_req & ~l_gnt;

  assign bw_en   = (h_gnt & h_wreq) | (l_gnt & loc_we_w);
  assign bw_addr = l_gnt ? loc_addr_w  : wbuf_addr_q;
  assign bw_data = l_gnt ? loc_wdata_w : wbuf_data_q;
  // While a prefetch is held the pointer still addresses the prefetched byte.
  assign inval   = bw_en & (bw_addr == ptr_q[AW-1:0]);

  always_comb begin
    ptr_d        = ptr_q;
    wbuf_vld_d   = wbuf_vld_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_data_d  = wbuf_data_q;
    rd_data_d    = rd_data_q;
    tok_d        = tok_q;
    loc_rdata_d  = loc_rdata_q;
    loc_rvalid_d = l_gnt & ~loc_we_w;

    if (user_mem_8_addr_update_w) ptr_d = {1'b0, user_mem_8_addr_w};
    else if (w_acc | r_acc)       ptr_d = ptr_inc;

    if (h_gnt & h_wreq) wbuf_vld_d = 1'b0;
    if (w_acc & in_range) begin
      wbuf_vld_d  = 1'b1;
      wbuf_addr_d = ptr_q[AW-1:0];
      wbuf_data_d = user_w_mem_8_data_w;
    end

    if (h_gnt & h_rreq)       rd_data_d   = bank_q[ptr_q[AW-1:0]];
    if (l_gnt & ~loc_we_w)    loc_rdata_d = bank_q[loc_addr_w];
    if (contested)            tok_d       = ~tok_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wbuf_vld_q)                                 state_d = h_gnt ? S_IDLE : S_WCOMMIT;
        else if (eof_hit & ~user_mem_8_addr_update_w)   state_d = S_EOF;
        else if (h_gnt)                                 state_d = S_FETCH;
      end
      S_WCOMMIT: if (h_gnt) state_d = S_IDLE;
      S_FETCH, S_VALID: begin
        if (user_mem_8_addr_update_w | r_acc | w_acc | inval | ~r_open) state_d = S_IDLE;
        else                                                            state_d = S_VALID;
      end
      S_EOF:   if (user_mem_8_addr_update_w) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk_w or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      ptr_q        <= '0;
      wbuf_vld_q   <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      state_q      <= S_IDLE;
      rd_data_q    <= '0;
      tok_q        <= 1'b0;
      loc_rdata_q  <= '0;
      loc_rvalid_q <= 1'b0;
    end else begin
      if (bw_en) bank_q[bw_addr] <= bw_data;
      ptr_q        <= ptr_d;
      wbuf_vld_q   <= wbuf_vld_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      state_q      <= state_d;
      rd_data_q    <= rd_data_d;
      tok_q        <= tok_d;
      loc_rdata_q  <= loc_rdata_d;
      loc_rvalid_q <= loc_rvalid_d;
    end
  end

  assign user_w_mem_8_full_w  = wbuf_vld_q;
  assign user_r_mem_8_data_w  = rd_data_q;
  assign user_r_mem_8_empty_w = ~pf_vld;
  assign user_r_mem_8_eof_w   = (state_q == S_EOF);
  assign loc_gnt_w            = l_gnt;
  assign loc_rdata_w          = loc_rdata_q;
  assign loc_rvalid_w         = loc_rvalid_q;

endmodule
